// File: rtl/resize_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | resize_engine                                                              |
// | Power-of-two image resize: upscale, decimate, block average or copy, from  |
// | a latency-ROM_LAT source ROM into a single frame-RAM write port.           |
// | Optional build macro: RESIZE_AVG_EN (enables mode 10, block average).      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module resize_engine #(
    parameter int SRC_W    = 160,
    parameter int SRC_H    = 120,
    parameter int PIX_W    = 8,
    parameter int ADDR_W   = 19,
    parameter int ROM_LAT  = 2,
    parameter int MAX_LOG2 = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [1:0]        mode,
    input  logic [1:0]        log2f,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [PIX_W-1:0]  rom_data,
    output logic [ADDR_W-1:0] ram_wraddr,
    output logic [PIX_W-1:0]  ram_data,
    output logic              ram_wren,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int c_CW = MAX_LOG2 + 1;
    localparam int c_DW = $clog2(ROM_LAT + 1) + 1;
    localparam logic [1:0] c_MODE_UP   = 2'b00;
    localparam logic [1:0] c_MODE_DEC  = 2'b01;
    localparam logic [1:0] c_MODE_AVG  = 2'b10;
    localparam logic [1:0] c_MODE_COPY = 2'b11;
    localparam logic [ADDR_W-1:0] c_SRC_W = ADDR_W'(SRC_W);
    localparam logic [ADDR_W-1:0] c_SRC_H = ADDR_W'(SRC_H);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            r_state;
    logic [1:0]        r_mode;
    logic [1:0]        r_k;
    logic [ADDR_W-1:0] r_ox;
    logic [ADDR_W-1:0] r_oy;
    logic [ADDR_W-1:0] r_oidx;
    logic [ADDR_W-1:0] r_rom_addr;
    logic              r_iss_vld;
    logic              r_busy;
    logic              r_done;
    logic              r_err;
    logic [c_DW-1:0]   r_dcnt;

    logic [ADDR_W-1:0] w_out_w;
    logic [ADDR_W-1:0] w_out_h;
    logic [ADDR_W-1:0] w_nx_ox;
    logic [ADDR_W-1:0] w_nx_oy;
    logic [ADDR_W-1:0] w_nx_oidx;
    logic [ADDR_W-1:0] w_nx_src;
    logic              w_ox_end;
    logic              w_oy_end;
    logic              w_blk_last;
    logic              w_last_read;
    logic              w_req_ok;
    logic              w_flush;

`ifdef RESIZE_AVG_EN
    assign w_req_ok = (mode == c_MODE_COPY) || (32'(log2f) <= MAX_LOG2);
`else
    assign w_req_ok = (mode == c_MODE_COPY) ||
                      ((32'(log2f) <= MAX_LOG2) && (mode != c_MODE_AVG));
`endif

    always_comb begin
        w_out_w = c_SRC_W;
        w_out_h = c_SRC_H;
        case (r_mode)
            c_MODE_UP: begin
                w_out_w = c_SRC_W << r_k;
                w_out_h = c_SRC_H << r_k;
            end
            c_MODE_DEC, c_MODE_AVG: begin
                w_out_w = c_SRC_W >> r_k;
                w_out_h = c_SRC_H >> r_k;
            end
            default: ;
        endcase
    end

`ifdef RESIZE_AVG_EN
    // Inner block counters; held at zero (single-read blocks) outside average mode.
    logic [c_CW-1:0] r_dx;
    logic [c_CW-1:0] r_dy;
    logic [c_CW-1:0] w_fm1;
    logic [c_CW-1:0] w_nx_dx;
    logic [c_CW-1:0] w_nx_dy;
    logic            w_is_avg;
    logic            w_dx_end;
    logic            w_dy_end;
    logic            w_blk_first;

    assign w_is_avg    = (r_mode == c_MODE_AVG);
    assign w_fm1       = c_CW'((1 << r_k) - 1);
    assign w_dx_end    = !w_is_avg || (r_dx == w_fm1);
    assign w_dy_end    = !w_is_avg || (r_dy == w_fm1);
    assign w_blk_first = !w_is_avg || ((r_dx == '0) && (r_dy == '0));
    assign w_blk_last  = w_dx_end && w_dy_end;
    assign w_nx_dx     = w_dx_end ? '0 : r_dx + 1'b1;
    assign w_nx_dy     = !w_dx_end ? r_dy : (w_dy_end ? '0 : r_dy + 1'b1);
`else
    assign w_blk_last  = 1'b1;
`endif

    assign w_ox_end    = (r_ox == w_out_w - 1'b1);
    assign w_oy_end    = (r_oy == w_out_h - 1'b1);
    assign w_last_read = w_blk_last && w_ox_end && w_oy_end;
    assign w_nx_ox     = !w_blk_last ? r_ox : (w_ox_end ? '0 : r_ox + 1'b1);
    assign w_nx_oy     = (w_blk_last && w_ox_end) ? r_oy + 1'b1 : r_oy;
    assign w_nx_oidx   = w_blk_last ? r_oidx + 1'b1 : r_oidx;

    always_comb begin
        w_nx_src = w_nx_oy * c_SRC_W + w_nx_ox;
        case (r_mode)
            c_MODE_UP:  w_nx_src = (w_nx_oy >> r_k) * c_SRC_W + (w_nx_ox >> r_k);
            c_MODE_DEC: w_nx_src = (w_nx_oy << r_k) * c_SRC_W + (w_nx_ox << r_k);
`ifdef RESIZE_AVG_EN
            c_MODE_AVG: w_nx_src = ((w_nx_oy << r_k) + ADDR_W'(w_nx_dy)) * c_SRC_W +
                                   (w_nx_ox << r_k) + ADDR_W'(w_nx_dx);
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_mode     <= '0;
            r_k        <= '0;
            r_ox       <= '0;
            r_oy       <= '0;
            r_oidx     <= '0;
            r_rom_addr <= '0;
            r_iss_vld  <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_dcnt     <= '0;
`ifdef RESIZE_AVG_EN
            r_dx       <= '0;
            r_dy       <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (w_req_ok) begin
                            r_state    <= S_RUN;
                            r_busy     <= 1'b1;
                            r_mode     <= mode;
                            r_k        <= (mode == c_MODE_COPY) ? 2'b00 : log2f;
                            r_ox       <= '0;
                            r_oy       <= '0;
                            r_oidx     <= '0;
                            r_rom_addr <= '0;
                            r_iss_vld  <= 1'b1;
`ifdef RESIZE_AVG_EN
                            r_dx       <= '0;
                            r_dy       <= '0;
`endif
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        r_state   <= S_IDLE;
                        r_busy    <= 1'b0;
                        r_iss_vld <= 1'b0;
                    end else if (w_last_read) begin
                        r_state   <= S_DRAIN;
                        r_iss_vld <= 1'b0;
                        r_dcnt    <= '0;
                    end else begin
                        r_ox       <= w_nx_ox;
                        r_oy       <= w_nx_oy;
                        r_oidx     <= w_nx_oidx;
                        r_rom_addr <= w_nx_src;
`ifdef RESIZE_AVG_EN
                        r_dx       <= w_nx_dx;
                        r_dy       <= w_nx_dy;
`endif
                    end
                end
                S_DRAIN: begin
                    if (abort) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else if (r_dcnt == c_DW'(ROM_LAT)) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_dcnt <= r_dcnt + 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Read pipeline: stage ROM_LAT-1 lines up with the ROM data for that read.
    logic [ROM_LAT-1:0] r_pv;
    logic [ADDR_W-1:0]  r_pa [ROM_LAT];
`ifdef RESIZE_AVG_EN
    logic [ROM_LAT-1:0] r_pf;
    logic [ROM_LAT-1:0] r_pl;
`endif

    assign w_flush = abort && ((r_state == S_RUN) || (r_state == S_DRAIN));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pv <= '0;
            for (int i = 0; i < ROM_LAT; i++) r_pa[i] <= '0;
`ifdef RESIZE_AVG_EN
            r_pf <= '0;
            r_pl <= '0;
`endif
        end else begin
            if (w_flush) begin
                r_pv <= '0;
            end else begin
                r_pv[0] <= r_iss_vld;
                for (int i = 1; i < ROM_LAT; i++) r_pv[i] <= r_pv[i-1];
            end
            r_pa[0] <= r_oidx;
            for (int i = 1; i < ROM_LAT; i++) r_pa[i] <= r_pa[i-1];
`ifdef RESIZE_AVG_EN
            r_pf[0] <= w_blk_first;
            r_pl[0] <= w_blk_last;
            for (int i = 1; i < ROM_LAT; i++) begin
                r_pf[i] <= r_pf[i-1];
                r_pl[i] <= r_pl[i-1];
            end
`endif
        end
    end

    logic [ADDR_W-1:0] r_wraddr;
    logic [PIX_W-1:0]  r_wdata;
    logic              r_wren;
    logic              w_tail_wr;

`ifdef RESIZE_AVG_EN
    logic [PIX_W+2*MAX_LOG2-1:0] r_acc;
    logic [PIX_W+2*MAX_LOG2-1:0] w_sum;
    logic [2:0]                  w_shamt;

    // The block's last sample is folded in combinationally so the write is not delayed.
    assign w_sum     = (r_pf[ROM_LAT-1] ? '0 : r_acc) + (PIX_W+2*MAX_LOG2)'(rom_data);
    assign w_shamt   = w_is_avg ? {r_k, 1'b0} : 3'd0;
    assign w_tail_wr = r_pv[ROM_LAT-1] && r_pl[ROM_LAT-1];
`else
    assign w_tail_wr = r_pv[ROM_LAT-1];
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wraddr <= '0;
            r_wdata  <= '0;
            r_wren   <= 1'b0;
`ifdef RESIZE_AVG_EN
            r_acc    <= '0;
`endif
        end else begin
            r_wren <= w_tail_wr && !w_flush;
            if (w_tail_wr) begin
                r_wraddr <= r_pa[ROM_LAT-1];
`ifdef RESIZE_AVG_EN
                r_wdata  <= PIX_W'(w_sum >> w_shamt);
`else
                r_wdata  <= rom_data;
`endif
            end
`ifdef RESIZE_AVG_EN
            if (r_pv[ROM_LAT-1]) r_acc <= w_sum;
`endif
        end
    end

    assign rom_addr   = r_rom_addr;
    assign ram_wraddr = r_wraddr;
    assign ram_data   = r_wdata;
    assign ram_wren   = r_wren;
    assign busy       = r_busy;
    assign done       = r_done;
    assign err        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_resize_engine.sv
`default_nettype none
// Scoreboard bench for resize_engine: a ROM model with fixed latency feeds the DUT,
// expected writes come from a coordinate-level reference model.
module tb_resize_engine;
    localparam int SW = 4, SH = 2, LAT = 2, ML = 2, AW = 19, PW = 8;

    logic          clk = 1'b0, reset = 1'b0, start = 1'b0, abort = 1'b0;
    logic [1:0]    mode = 2'b00, log2f = 2'b00;
    logic [AW-1:0] rom_addr, ram_wraddr;
    logic [PW-1:0] rom_data, ram_data;
    logic          ram_wren, busy, done, err;

    logic [7:0] rom [SW*SH];
    logic [7:0] rd1 = 8'd0, rd2 = 8'd0;
    int cyc = 0, checks = 0, failures = 0;

    typedef struct {int addr; int data; int cyc;} wr_t;
    wr_t q[$];

    resize_engine #(.SRC_W(SW), .SRC_H(SH), .PIX_W(PW), .ADDR_W(AW),
                    .ROM_LAT(LAT), .MAX_LOG2(ML)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .mode(mode),
        .log2f(log2f), .rom_addr(rom_addr), .rom_data(rom_data),
        .ram_wraddr(ram_wraddr), .ram_data(ram_data), .ram_wren(ram_wren),
        .busy(busy), .done(done), .err(err));

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        rd1 <= rom[int'(rom_addr) % (SW*SH)];
        rd2 <= rd1;
    end
    assign rom_data = rd2;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (reset && ram_wren) begin
            if (q.size() == 0) begin
                check("write_without_expectation", 32'(ram_wren), 32'd0);
            end else begin
                wr_t e;
                e = q.pop_front();
                check("wr_addr", 32'(ram_wraddr), e.addr);
                check("wr_data", 32'(ram_data), e.data);
                check("wr_cycle", cyc, e.cyc);
            end
        end
    end

    // Reference: output pixel (ox,oy) of each mode, in row-major order.
    task automatic expect_op(input int m, input int k, input int t0, input int lim,
                             output int nreads);
        int ow, oh, f, i, s;
        wr_t e;
        f = (m == 3) ? 1 : (1 << k);
        case (m)
            0:       begin ow = SW * f; oh = SH * f; end
            1, 2:    begin ow = SW / f; oh = SH / f; end
            default: begin ow = SW;     oh = SH;     end
        endcase
        i = 0;
        for (int oy = 0; oy < oh; oy++) begin
            for (int ox = 0; ox < ow; ox++) begin
                case (m)
                    0: s = int'(rom[(oy / f) * SW + ox / f]);
                    1: s = int'(rom[(oy * f) * SW + ox * f]);
                    2: begin
                        s = 0;
                        for (int dy = 0; dy < f; dy++)
                            for (int dx = 0; dx < f; dx++)
                                s += int'(rom[(oy * f + dy) * SW + ox * f + dx]);
                        s = s / (f * f);
                    end
                    default: s = int'(rom[oy * SW + ox]);
                endcase
                e.addr = oy * ow + ox;
                e.data = s;
                e.cyc  = (m == 2) ? t0 + (i + 1) * f * f + LAT : t0 + i + LAT + 1;
                if (i < lim) q.push_back(e);
                i++;
            end
        end
        nreads = (m == 2) ? ow * oh * f * f : ow * oh;
    endtask

    task automatic launch(input int m, input int k, output int t0);
        @(negedge clk);
        mode  = 2'(m);
        log2f = 2'(k);
        start = 1'b1;
        @(posedge clk);
        #1;
        t0    = cyc;
        start = 1'b0;
    endtask

    task automatic run_op(input int m, input int k, input bit rnd);
        int t0, n;
        launch(m, k, t0);
        expect_op(m, k, t0, 1 << 30, n);
        for (int c = 1; c <= n + LAT + 4; c++) begin
            @(negedge clk);
            check("busy", 32'(busy), 32'(c <= n + LAT + 2));
            check("done", 32'(done), 32'(c == n + LAT + 2));
            check("err_quiet", 32'(err), 32'd0);
            if (rnd && c < n) begin
                start = 1'($urandom % 2);
                mode  = 2'($urandom);
                log2f = 2'($urandom);
            end else begin
                start = 1'b0;
            end
        end
        check("scoreboard_empty", q.size(), 32'd0);
    endtask

    task automatic illegal(input int m, input int k);
        int t0;
        launch(m, k, t0);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            check("err_pulse", 32'(err), 32'(c == 1));
            check("busy_illegal", 32'(busy), 32'd0);
        end
    endtask

    task automatic abort_test();
        int t0, n;
        launch(0, 1, t0);
        expect_op(0, 1, t0, 3, n);
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            check("abort_busy", 32'(busy), 32'(c < 7));
            check("abort_done", 32'(done), 32'd0);
            abort = (c == 6);
        end
        check("abort_scoreboard", q.size(), 32'd0);
    endtask

    task automatic reset_test();
        int t0, n;
        launch(0, 1, t0);
        expect_op(0, 1, t0, 2, n);
        repeat (5) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("rst_rom_addr", 32'(rom_addr), 32'd0);
        check("rst_wraddr", 32'(ram_wraddr), 32'd0);
        check("rst_data", 32'(ram_data), 32'd0);
        check("rst_wren", 32'(ram_wren), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        q.delete();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int m, k;
        for (int i = 0; i < SW*SH; i++) rom[i] = 8'(i * 10);
        repeat (3) @(posedge clk);
        #1;
        check("init_rom_addr", 32'(rom_addr), 32'd0);
        check("init_wraddr", 32'(ram_wraddr), 32'd0);
        check("init_data", 32'(ram_data), 32'd0);
        check("init_wren", 32'(ram_wren), 32'd0);
        check("init_busy", 32'(busy), 32'd0);
        check("init_done", 32'(done), 32'd0);
        check("init_err", 32'(err), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        run_op(3, 0, 1'b0);
        run_op(0, 1, 1'b0);
        run_op(1, 1, 1'b0);
`ifdef RESIZE_AVG_EN
        rom[0] = 8'd10; rom[1] = 8'd20; rom[4] = 8'd30; rom[5] = 8'd40;
        run_op(2, 1, 1'b0);
        for (int i = 0; i < SW*SH; i++) rom[i] = 8'd255;
        run_op(2, 1, 1'b0);
        for (int i = 0; i < SW*SH; i++) rom[i] = 8'(i * 10);
`else
        illegal(2, 1);
`endif
        illegal(0, 3);
        abort_test();
        run_op(0, 1, 1'b0);
        reset_test();
        run_op(3, 0, 1'b0);
        run_op(0, 2, 1'b0);

        repeat (8) begin
            for (int i = 0; i < SW*SH; i++) rom[i] = 8'($urandom);
            m = int'($urandom % 4);
`ifndef RESIZE_AVG_EN
            if (m == 2) m = 3;
`endif
            k = (m == 0 || m == 3) ? int'($urandom_range(0, 2)) : int'($urandom_range(0, 1));
            run_op(m, k, 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/resize_engine.md
# resize_engine

Parametrised image-resize engine for the video path between the source image ROM and the VGA frame RAM. It generates addresses for nearest-neighbour upscale, decimation, block average or direct copy at a runtime-selectable power-of-two factor, and writes results through one shared write port. Operations are launched with a start/busy/done handshake and can be aborted. It replaces the fixed-factor per-algorithm instances plus the output multiplexer with a single engine.

## Interface
- SRC_W, 160: source image width in pixels.
- SRC_H, 120: source image height in pixels.
- PIX_W, 8: pixel width.
- ADDR_W, 19: ROM/RAM address width; must hold (SRC_W*SRC_H)<<(2*MAX_LOG2).
- ROM_LAT, 2: ROM read latency in cycles, ≥1.
- MAX_LOG2, 2: largest legal log2 of the factor.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-low.
- start  in  1  launch request; sampled only in IDLE.
- abort  in  1  cancel the current operation.
- mode  in  2  00 upscale, 01 decimate, 10 block average, 11 copy.
- log2f  in  2  factor = 1<<log2f; ignored for copy.
- rom_addr  out  ADDR_W  source read address.
- rom_data  in  PIX_W  ROM data, ROM_LAT cycles after rom_addr.
- ram_wraddr  out  ADDR_W  destination write address.
- ram_data  out  PIX_W  destination write data.
- ram_wren  out  1  write strobe.
- busy  out  1  operation in progress.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle illegal-request pulse.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE → RUN on start:
  - mode and log2f are latched.
  - Output counters ox and oy are cleared.
- Illegal request: log2f > MAX_LOG2, or mode 10 without the macro. The engine pulses err for one cycle, stays in IDLE, and busy stays 0.
- Output size per mode, with k = log2f:
  - Upscale: (SRC_W<<k) × (SRC_H<<k).
  - Decimate and average: (SRC_W>>k) × (SRC_H>>k).
  - Copy: SRC_W × SRC_H.
- Output pixels are produced row-major. ram_wraddr = oy*OUT_W + ox.
- Source address per mode:
  - Upscale: (oy>>k)*SRC_W + (ox>>k).
  - Decimate: (oy<<k)*SRC_W + (ox<<k).
  - Copy: identity.
  - In these modes one read is issued per cycle.
- Average: for each output pixel, F×F reads are issued, ordered row-major (dy outer, dx inner).
  - The accumulator is PIX_W+2*MAX_LOG2 bits wide.
  - Output = sum >> 2k, truncated.
  - The accumulator is cleared at each block start.
- RUN → DRAIN after the last read is issued.
- DRAIN lasts ROM_LAT+1 cycles, until the write pipeline is empty. It then moves to DONE.
- DONE: done=1 for one cycle, then IDLE.
- busy is 1 in RUN, DRAIN and DONE.
- start while busy is ignored.
- abort in RUN or DRAIN:
  - Next state is IDLE and the pipeline valid bits are flushed.
  - ram_wren is 0 from the next cycle.
  - No done pulse.
  - abort in IDLE has no effect.
- Asynchronous reset mid-operation forces IDLE. All outputs go to 0, with no pending writes.

## Timing
- Reset values: rom_addr, ram_wraddr and ram_data are 0; ram_wren, busy, done and err are 0.
- Start is sampled at edge e0. Cycle 1 is the first cycle after e0; busy=1 and the first rom_addr is valid in cycle 1.
- A read issued in cycle c produces its ram_wren/ram_wraddr/ram_data in cycle c+ROM_LAT+1, all registered.
- Average mode: the write for a block occurs ROM_LAT+1 cycles after the block's last read.
- With N total reads:
  - The last write is in cycle N+ROM_LAT+1.
  - done is in cycle N+ROM_LAT+2.
  - busy falls in cycle N+ROM_LAT+3.
- err is asserted in cycle 1 for an illegal start.
- Throughput is one read per cycle with no bubbles, including across row and block boundaries.

## Configuration
- RESIZE_AVG_EN defined: mode 10 performs the block average, and the accumulator and block counters are compiled in.
- RESIZE_AVG_EN undefined: mode 10 is illegal (err pulse, no operation), and the accumulator logic is absent.

## Test plan
Bench parameters: SRC_W=4, SRC_H=2, ROM_LAT=2, MAX_LOG2=2, ROM[i]=i*10.
- Copy, start at e0:
  - 8 writes, in cycles 4..11.
  - Addresses 0..7, data 0,10,...,70.
  - done in cycle 12.
- Upscale, k=1:
  - 32 writes, ram_wraddr 0..31.
  - Write 1 has data 0.
  - Write 2 has data 10.
  - Write 8 (row 1) has data 0.
  - done once.
- Decimate, k=1:
  - 2 writes: wraddr 0 from src 0 (data 0), wraddr 1 from src 2 (data 20).
- Average, k=1, with RESIZE_AVG_EN and ROM[0,1,4,5]=10,20,30,40:
  - Write 0 = 25.
  - All-255 ROM gives 255, with no overflow.
- Illegal requests:
  - log2f=3 → err high exactly 1 cycle, busy 0, no ram_wren.
  - Same result for mode 10 without RESIZE_AVG_EN.
- Abort and reset mid-operation:
  - abort in cycle 6 of an upscale → ram_wren 0 from cycle 7, busy 0, no done.
  - A new start afterwards completes normally.
  - reset low mid-RUN → all outputs 0 immediately.
